dbg_bus_master: RTL and testbench
=================================

DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum number of cycles spent in WAIT before a transaction is abandoned; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_addr  input  32  byte address of the command.
REQ-007 cmd_w_rb  input  1  1 = write, 0 = read.
REQ-008 cmd_acc  input  `BUS_ACC_WIDTH  access size (`BUS_ACC_1B / `BUS_ACC_2B / `BUS_ACC_4B).
REQ-009 cmd_wdata  input  `BUS_WIDTH  write data, right-aligned.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-012 rsp_status  output  2  `DBG_STS_OK / `DBG_STS_FAULT / `DBG_STS_TIMEOUT.
REQ-013 rsp_rdata  output  `BUS_WIDTH  read data; 0 for writes and for non-OK statuses.
REQ-014 addr, w_rb, acc, wdata  output  32, 1, `BUS_ACC_WIDTH, `BUS_WIDTH  bus request fields.
REQ-015 req  output  1  single-cycle bus request strobe.
REQ-016 resp  input  1  responder completion, registered at the responder, arrives at least 1 cycle after req.
REQ-017 fault  input  1  combinational responder reject, valid only in the req cycle.
REQ-018 rdata  input  `BUS_WIDTH  read data, valid in the resp cycle.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and RSP, encoded in 2 bits.
REQ-020 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches all cmd_* fields into the bus field registers and goes to REQ; otherwise the FSM stays in IDLE.
REQ-021 cmd_ready SHALL be 0 in every state other than IDLE; at most one transaction is outstanding.
REQ-022 REQ: req=1 for exactly one cycle; fault=1 gives status FAULT and goes to RSP; otherwise the FSM goes to WAIT with the timeout counter cleared to 0.
REQ-023 WAIT: resp=1 gives status OK, captures rdata for a read (0 for a write) and goes to RSP.
REQ-024 WAIT without resp: the counter increments; when the counter equals TIMEOUT-1 and resp=0, the status is TIMEOUT and the FSM goes to RSP; resp in that same cycle wins (status OK).
REQ-025 RSP: rsp_valid=1, with rsp_status and rsp_rdata held stable; rsp_valid&rsp_ready goes to IDLE.
REQ-026 resp or fault sampled in IDLE, RSP, or resp in REQ (stale from a timed-out transaction) SHALL be ignored.
REQ-027 addr/w_rb/acc/wdata SHALL remain stable from REQ until the next command is accepted.
REQ-028 Latency: with command accepted in cycle N, req is in N+1; with a 1-cycle responder, rsp_valid is in N+3.
REQ-029 The block SHALL NOT pre-check alignment; misalignment is reported only through fault.
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-031 Reset SHALL force state=IDLE, cmd_ready=1, req=0, rsp_valid=0, rsp_status=`DBG_STS_OK, rsp_rdata=0, addr=0, w_rb=0, acc=`BUS_ACC_1B, wdata=0, counter=0.
REQ-032 Reset asserted mid-transaction (REQ/WAIT/RSP) SHALL drop the transaction with no response; a later resp SHALL be ignored under REQ-026.

Structure
REQ-033 `DBG_STS_OK=2'd0, `DBG_STS_FAULT=2'd1 and `DBG_STS_TIMEOUT=2'd2 SHALL be defined in femto.vh beside the existing `BUS_ACC_* macros.
REQ-034 The block is a single module with no sub-module; the FSM, counter and capture registers live together.

Verification
REQ-035 Write 4B 0xDEADBEEF to 0x10, then read 4B 0x10 against the debug TCM -> both OK; the read gives rsp_rdata=0xDEADBEEF; rsp_valid is 3 cycles after each accept.
REQ-036 Read 2B at 0x1 -> fault in the req cycle; status FAULT, rsp_rdata=0, no WAIT cycle.
REQ-037 Responder never asserts resp, TIMEOUT=8 -> status TIMEOUT with rsp_valid 10 cycles after accept; a resp injected afterwards is ignored.
REQ-038 rsp_ready held low 5 cycles after OK read 0x12345678 -> rsp_valid/data stable for 6 cycles, cmd_ready=0 throughout, and the next command is accepted the cycle after the response handshake.
REQ-039 rst pulsed in WAIT, then a late resp -> all outputs equal reset values, no rsp_valid, next command completes OK.

Source files
------------

// File: rtl/dbg_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// dbg_bus_master_pkg
// Shared constants for the debug bus master and its environment: bus widths,
// access-size encodings, response status codes and the FSM state type.
// The classic `BUS_* / `DBG_STS_* macros are also provided (guarded) so code
// written against the macro names keeps compiling; new code should use the
// typed localparams below.
// ---------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef DBG_STS_OK
`define DBG_STS_OK 2'd0
`endif
`ifndef DBG_STS_FAULT
`define DBG_STS_FAULT 2'd1
`endif
`ifndef DBG_STS_TIMEOUT
`define DBG_STS_TIMEOUT 2'd2
`endif

package dbg_bus_master_pkg;

   localparam int BUS_WIDTH     = 32;
   localparam int BUS_ACC_WIDTH = 2;

   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

   localparam logic [1:0] DBG_STS_OK      = 2'd0;
   localparam logic [1:0] DBG_STS_FAULT   = 2'd1;
   localparam logic [1:0] DBG_STS_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } dbg_state_e;

endpackage

// File: rtl/dbg_bus_master.sv
// ---------------------------------------------------------------------------
// dbg_bus_master
// Turns one debug command at a time into a single bus transaction and returns
// a status/data response.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_addr/cmd_w_rb/cmd_acc/cmd_wdata  command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_status/rsp_rdata           response status and read data
//   addr/w_rb/acc/wdata            bus request fields (held until next accept)
//   req                            one-cycle bus request strobe
//   resp                           responder completion (>=1 cycle after req)
//   fault                          combinational responder reject in req cycle
//   rdata                          responder read data, valid with resp
//
// Parameter TIMEOUT (1..65535): cycles allowed in WAIT before giving up.
// ---------------------------------------------------------------------------
module dbg_bus_master
   import dbg_bus_master_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [31:0]              cmd_addr,
   input  logic                     cmd_w_rb,
   input  logic [BUS_ACC_WIDTH-1:0] cmd_acc,
   input  logic [BUS_WIDTH-1:0]     cmd_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [1:0]               rsp_status,
   output logic [BUS_WIDTH-1:0]     rsp_rdata,
   output logic [31:0]              addr,
   output logic                     w_rb,
   output logic [BUS_ACC_WIDTH-1:0] acc,
   output logic [BUS_WIDTH-1:0]     wdata,
   output logic                     req,
   input  logic                     resp,
   input  logic                     fault,
   input  logic [BUS_WIDTH-1:0]     rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Last WAIT cycle index; counter stops here so it can never wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   dbg_state_e                 state_q, state_d;
   logic [31:0]                addr_q, addr_d;
   logic                       w_rb_q, w_rb_d;
   logic [BUS_ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [BUS_WIDTH-1:0]       wdata_q, wdata_d;
   logic [1:0]                 sts_q, sts_d;
   logic [BUS_WIDTH-1:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         w_rb_q  <= 1'b0;
         acc_q   <= BUS_ACC_1B;
         wdata_q <= '0;
         sts_q   <= DBG_STS_OK;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         w_rb_q  <= w_rb_d;
         acc_q   <= acc_d;
         wdata_q <= wdata_d;
         sts_q   <= sts_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // resp/fault are only looked at in the state where they are meaningful, so
   // stale completions (after a timeout or a reset) fall on the floor.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      w_rb_d    = w_rb_q;
      acc_d     = acc_q;
      wdata_d   = wdata_q;
      sts_d     = sts_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      cmd_ready = 1'b0;
      req       = 1'b0;
      rsp_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               w_rb_d  = cmd_w_rb;
               acc_d   = cmd_acc;
               wdata_d = cmd_wdata;
               sts_d   = DBG_STS_OK;
               rdata_d = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            req = 1'b1;
            if (fault) begin
               sts_d   = DBG_STS_FAULT;
               rdata_d = '0;
               state_d = ST_RSP;
            end else begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A completion in the final WAIT cycle still counts as OK.
            if (resp) begin
               sts_d   = DBG_STS_OK;
               rdata_d = w_rb_q ? '0 : rdata;
               state_d = ST_RSP;
            end else if (cnt_q == CNT_LAST) begin
               sts_d   = DBG_STS_TIMEOUT;
               rdata_d = '0;
               state_d = ST_RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign addr       = addr_q;
   assign w_rb       = w_rb_q;
   assign acc        = acc_q;
   assign wdata      = wdata_q;
   assign rsp_status = sts_q;
   assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_dbg_bus_master
// Drives directed and random debug commands into dbg_bus_master with a byte
// memory responder (variable latency, never-respond, misalignment faults,
// spurious fault noise) and checks every cycle against a transaction-level
// expectation: accept cycle, response cycle, handshake cycle, status, data.
// ---------------------------------------------------------------------------
module tb_dbg_bus_master;
   import dbg_bus_master_pkg::*;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic        cmd_w_rb = 1'b0;
   logic [1:0]  cmd_acc = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_rdata;
   logic [31:0] addr;
   logic        w_rb;
   logic [1:0]  acc;
   logic [31:0] wdata;
   logic        req;
   logic        resp = 1'b0;
   logic        fault;
   logic [31:0] rdata = '0;

   dbg_bus_master #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_w_rb(cmd_w_rb), .cmd_acc(cmd_acc), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
      .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
      .req(req), .resp(resp), .fault(fault), .rdata(rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- memories and helpers ----------------
   logic [7:0] tcm     [256];
   logic [7:0] ref_mem [256];

   function automatic int acc_bytes(input logic [1:0] ac);
      case (ac)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic is_mis(input logic [31:0] a, input logic [1:0] ac);
      int n;
      n = acc_bytes(ac);
      if (n == 0) return 1'b1;
      return (int'(a[7:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] tcm_rd(input logic [31:0] a, input logic [1:0] ac);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < acc_bytes(ac); i++) v[8*i +: 8] = tcm[8'(a + 32'(i))];
      return v;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] ac);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < acc_bytes(ac); i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
      return v;
   endfunction

   // ---------------- responder ----------------
   int   lat_cfg = 1;      // cycles from req to resp; 0 = never respond
   logic fault_noise = 1'b0;

   assign fault = req ? is_mis(addr, acc) : fault_noise;

   initial begin
      int          cd;
      logic        rw;
      logic [31:0] ra;
      logic [1:0]  racc;
      cd = 0; rw = 1'b0; ra = '0; racc = '0;
      forever begin
         next_cycle();
         resp  = 1'b0;
         rdata = $urandom;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               resp = 1'b1;
               if (!rw) rdata = tcm_rd(ra, racc);
            end
         end
         if (req && !fault) begin
            if (w_rb) begin
               for (int i = 0; i < acc_bytes(acc); i++) tcm[8'(addr + 32'(i))] = wdata[8*i +: 8];
            end
            rw = w_rb; ra = addr; racc = acc;
            cd = lat_cfg;
         end
         fault_noise = ($urandom_range(0, 3) == 0);
      end
   end

   // ---------------- transaction-level model ----------------
   logic        rec_valid = 1'b0;
   int          r_acc = 0, r_rsp = 0, r_hs = 0;
   logic [1:0]  e_sts = '0;
   logic [31:0] e_data = '0;
   logic [31:0] cur_addr = '0, prev_addr = '0;
   logic        cur_wrb = 1'b0, prev_wrb = 1'b0;
   logic [1:0]  cur_acc = '0, prev_acc = '0;
   logic [31:0] cur_wd = '0, prev_wd = '0;
   logic        started = 1'b0;

   task automatic set_fields_reset();
      rec_valid = 1'b0;
      prev_addr = '0; prev_wrb = 1'b0; prev_acc = BUS_ACC_1B; prev_wd = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_req"},       32'(req),       32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_status"},    32'(rsp_status), 32'(DBG_STS_OK));
      chk({tag, "_rdata"},     rsp_rdata,      32'd0);
      chk({tag, "_addr"},      addr,           32'd0);
      chk({tag, "_w_rb"},      32'(w_rb),      32'd0);
      chk({tag, "_acc"},       32'(acc),       32'(BUS_ACC_1B));
      chk({tag, "_wdata"},     wdata,          32'd0);
   endtask

   // Applies a command in the current cycle and records what must follow.
   task automatic start_cmd(input logic w, input logic [31:0] a, input logic [1:0] ac,
                            input logic [31:0] wd, input int lat, input int dly,
                            output int off);
      logic mis;
      mis = is_mis(a, ac);
      if (mis) begin
         e_sts = DBG_STS_FAULT; e_data = '0; off = 2;
      end else if (lat >= 1 && lat <= T) begin
         e_sts = DBG_STS_OK; e_data = w ? 32'd0 : ref_rd(a, ac); off = 2 + lat;
      end else begin
         e_sts = DBG_STS_TIMEOUT; e_data = '0; off = T + 2;
      end
      // The responder commits writes when it accepts the request.
      if (!mis && w) begin
         for (int i = 0; i < acc_bytes(ac); i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
      end
      if (rec_valid) begin
         prev_addr = cur_addr; prev_wrb = cur_wrb; prev_acc = cur_acc; prev_wd = cur_wd;
      end
      cur_addr = a; cur_wrb = w; cur_acc = ac; cur_wd = wd;
      lat_cfg   = lat;
      cmd_valid = 1'b1;
      cmd_addr  = a; cmd_w_rb = w; cmd_acc = ac; cmd_wdata = wd;
      r_acc = cyc; r_rsp = cyc + off; r_hs = cyc + off + dly;
      rec_valid = 1'b1;
   endtask

   task automatic do_txn(input logic w, input logic [31:0] a, input logic [1:0] ac,
                         input logic [31:0] wd, input int lat, input int dly,
                         output logic [1:0] got_sts, output logic [31:0] got_data,
                         output int off);
      start_cmd(w, a, ac, wd, lat, dly, off);
      next_cycle();
      cmd_valid = 1'b0;
      cmd_addr = $urandom; cmd_w_rb = 1'($urandom); cmd_acc = 2'($urandom); cmd_wdata = $urandom;
      while (cyc < r_hs) begin
         rsp_ready = (cyc < r_rsp) ? 1'($urandom) : 1'b0;
         next_cycle();
      end
      rsp_ready = 1'b1;
      got_sts   = rsp_status;
      got_data  = rsp_rdata;
      next_cycle();
      rsp_ready = 1'b0;
      $display("txn %s addr=%h acc=%0d wdata=%h lat=%0d -> sts=%0d rdata=%h",
               w ? "WR" : "RD", a, ac, wd, lat, got_sts, got_data);
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin
      logic busy, is_req, in_rsp, use_cur;
      forever begin
         @(negedge clk);
         if (started && !rst) begin
            busy    = rec_valid && cyc > r_acc && cyc <= r_hs;
            is_req  = rec_valid && cyc == r_acc + 1;
            in_rsp  = rec_valid && cyc >= r_rsp && cyc <= r_hs;
            use_cur = rec_valid && cyc > r_acc;
            chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
            chk("req",       32'(req),       32'(is_req));
            chk("rsp_valid", 32'(rsp_valid), 32'(in_rsp));
            if (in_rsp) begin
               chk("rsp_status", 32'(rsp_status), 32'(e_sts));
               chk("rsp_rdata",  rsp_rdata,      e_data);
            end
            chk("bus_addr",  addr,        use_cur ? cur_addr : prev_addr);
            chk("bus_w_rb",  32'(w_rb),   32'(use_cur ? cur_wrb : prev_wrb));
            chk("bus_acc",   32'(acc),    32'(use_cur ? cur_acc : prev_acc));
            chk("bus_wdata", wdata,       use_cur ? cur_wd : prev_wd);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]  s;
      logic [31:0] d;
      int          off;
      for (int i = 0; i < 256; i++) begin
         tcm[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      set_fields_reset();

      // Asynchronous reset: outputs must settle before any clock edge.
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;
      next_cycle();

      // Write then read back 4 bytes with a 1-cycle responder.
      do_txn(1'b1, 32'h10, BUS_ACC_4B, 32'hDEADBEEF, 1, 0, s, d, off);
      chk("wr_status", 32'(s), 32'(DBG_STS_OK));
      chk("wr_rdata", d, 32'd0);
      chk("wr_latency", 32'(off), 32'd3);
      do_txn(1'b0, 32'h10, BUS_ACC_4B, 32'h0, 1, 0, s, d, off);
      chk("rd_status", 32'(s), 32'(DBG_STS_OK));
      chk("rd_rdata", d, 32'hDEADBEEF);
      chk("rd_latency", 32'(off), 32'd3);

      // Misaligned halfword read is rejected in the req cycle.
      do_txn(1'b0, 32'h1, BUS_ACC_2B, 32'h0, 1, 0, s, d, off);
      chk("fault_status", 32'(s), 32'(DBG_STS_FAULT));
      chk("fault_rdata", d, 32'd0);
      chk("fault_latency", 32'(off), 32'd2);

      // Responder too slow: timeout, and its late resp lands in RSP.
      do_txn(1'b0, 32'h10, BUS_ACC_4B, 32'h0, T + 3, 3, s, d, off);
      chk("to_status", 32'(s), 32'(DBG_STS_TIMEOUT));
      chk("to_rdata", d, 32'd0);
      chk("to_latency", 32'(off), 32'd10);

      // Back-pressured read response, then an immediate next command.
      do_txn(1'b1, 32'h20, BUS_ACC_4B, 32'h12345678, 2, 0, s, d, off);
      do_txn(1'b0, 32'h20, BUS_ACC_4B, 32'h0, 1, 5, s, d, off);
      chk("bp_status", 32'(s), 32'(DBG_STS_OK));
      chk("bp_rdata", d, 32'h12345678);
      do_txn(1'b0, 32'h22, BUS_ACC_2B, 32'h0, T, 0, s, d, off);
      chk("lastwait_status", 32'(s), 32'(DBG_STS_OK));
      chk("lastwait_rdata", d, 32'h00001234);

      // Reset while waiting, a late resp afterwards, then a clean command.
      start_cmd(1'b0, 32'h20, BUS_ACC_4B, 32'h0, 4, 0, off);
      next_cycle();
      cmd_valid = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1 check_reset_vals("rst_wait");
      set_fields_reset();
      next_cycle();
      rst = 1'b0;
      repeat (6) next_cycle();
      do_txn(1'b0, 32'h20, BUS_ACC_4B, 32'h0, 1, 0, s, d, off);
      chk("post_rst_status", 32'(s), 32'(DBG_STS_OK));
      chk("post_rst_rdata", d, 32'h12345678);

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         logic        w;
         logic [31:0] a, wd;
         logic [1:0]  ac;
         int          lat, r, nb;
         w  = 1'($urandom);
         ac = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
         nb = acc_bytes(ac);
         if (nb > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
         wd = $urandom;
         r  = $urandom_range(0, 9);
         if (r == 0) lat = 0;
         else if (r <= 6) lat = $urandom_range(1, T);
         else lat = $urandom_range(T + 1, T + 3);
         repeat ($urandom_range(0, 2)) next_cycle();
         do_txn(w, a, ac, wd, lat, $urandom_range(0, 3), s, d, off);
      end

      repeat (4) next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
